// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier controller and its datapath.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } mult_state_t;

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the multiplier sequencer; tc flags the last iteration
// and the count wraps to zero there instead of running past WIDTH-1.
module mult_iter_cnt #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier: load, WIDTH add/shift iterations, done.
//
//   state | meaning
//   IDLE  | waiting for start; ready holds the last result status
//   LOAD  | Product <= {0, multiplier}; iteration count cleared
//   ITER  | add-and-shift (lsb=1) or shift-only (lsb=0), one per cycle
//   DONE  | one-cycle done pulse; Product holds the final result
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             product_lsb,
    output logic             wrctrl,
    output logic             strctrl,
    output logic             shctrl,
    output logic             alu_en,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    mult_state_t state;
    logic        cnt_clr;
    logic        cnt_en;
    logic        last_iter;

    assign cnt_clr = (state == LOAD);
    assign cnt_en  = (state == ITER);

    mult_iter_cnt #(
        .WIDTH (WIDTH)
    ) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (iter),
        .tc    (last_iter)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= ITER;
                    ready <= 1'b0;
                end
                ITER: begin
                    if (last_iter) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // product_lsb is passed through unmasked so an X on it is visible downstream.
    assign wrctrl  = (state == LOAD);
    assign strctrl = (state == ITER) & product_lsb;
    assign shctrl  = (state == ITER) & ~product_lsb;
    assign alu_en  = strctrl;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: models the Product register around the controller and
// scores each multiply against the arithmetic product and its expected timing.
module tb_mult_ctrl;
    import mult_pkg::*;

    localparam int W  = MULT_WIDTH;
    localparam int CW = $clog2(W);

    typedef struct packed {
        logic [31:0] mcand;
        logic [31:0] mplier;
        logic [63:0] exp_prod;
        int          load_edge;
    } job_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          product_lsb;
    logic          wrctrl, strctrl, shctrl, alu_en, ready, busy, done;
    logic [CW-1:0] iter;

    logic          start4;
    logic          lsb4;
    logic          wrctrl4, strctrl4, shctrl4, alu_en4, ready4, busy4, done4;
    logic [1:0]    iter4;

    logic [63:0]   prod  = '0;
    logic [7:0]    prod4 = '0;
    logic [3:0]    pat_str = 4'b1010;

    int            edge_cnt = 0;
    bit            rst_seen;
    int            n_checks = 0;
    int            n_errors = 0;
    int            it_exp;
    job_t          sb[$];
    job_t          cur;
    bit            active;
    bit            ready_exp;

    always #5 clk = ~clk;

    assign product_lsb = prod[0];
    assign lsb4        = prod4[0];

    mult_ctrl dut32 (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .product_lsb (product_lsb),
        .wrctrl      (wrctrl),
        .strctrl     (strctrl),
        .shctrl      (shctrl),
        .alu_en      (alu_en),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .iter        (iter)
    );

    mult_ctrl #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .start       (start4),
        .product_lsb (lsb4),
        .wrctrl      (wrctrl4),
        .strctrl     (strctrl4),
        .shctrl      (shctrl4),
        .alu_en      (alu_en4),
        .ready       (ready4),
        .busy        (busy4),
        .done        (done4),
        .iter        (iter4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] add_shift(input logic [63:0] p, input logic [31:0] m);
        logic [32:0] s;
        logic [64:0] t;
        s = {1'b0, p[63:32]} + {1'b0, m};
        t = {s, p[31:0]};
        return t[64:1];
    endfunction

    // Product register models, driven by the controller outputs seen at the edge.
    always @(posedge clk) begin
        logic [4:0] s4;
        logic [8:0] t4;
        edge_cnt <= edge_cnt + 1;
        rst_seen <= !reset;
        if (wrctrl)       prod <= {32'd0, cur.mplier};
        else if (strctrl) prod <= add_shift(prod, cur.mcand);
        else if (shctrl)  prod <= prod >> 1;
        s4 = {1'b0, prod4[7:4]} + 5'd3;
        t4 = {s4, prod4[3:0]};
        if (wrctrl4)       prod4 <= {4'd0, 4'b1010};
        else if (strctrl4) prod4 <= t4[8:1];
        else if (shctrl4)  prod4 <= prod4 >> 1;
    end

    always @(negedge clk) begin
        if (rst_seen) begin
            chk("reset_outs", 64'({wrctrl, strctrl, shctrl, alu_en, ready, busy, done, iter}), 64'd0);
            active    = 1'b0;
            ready_exp = 1'b0;
        end else begin
            chk("onehot", 64'($onehot0({wrctrl, strctrl, shctrl})), 64'd1);
            chk("ready", 64'(ready), 64'(ready_exp));
            if (wrctrl) begin
                chk("load_expected", 64'(sb.size() > 0 && !active), 64'd1);
                if (sb.size() > 0) begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                    chk("load_cycle", 64'(edge_cnt), 64'(cur.load_edge));
                end
                chk("load_busy", 64'(busy), 64'd1);
                ready_exp = 1'b0;
            end else if (strctrl || shctrl) begin
                it_exp = edge_cnt - cur.load_edge - 1;
                chk("iter_active", 64'(active), 64'd1);
                chk("iter_range", 64'(it_exp >= 0 && it_exp < W), 64'd1);
                chk("iter", 64'(iter), 64'(it_exp));
                chk("lsb_known", 64'($isunknown(product_lsb)), 64'd0);
                chk("iter_busy", 64'(busy), 64'd1);
                if (it_exp >= 0 && it_exp < W) begin
                    chk("strctrl", 64'(strctrl), 64'(cur.mplier[it_exp]));
                    chk("shctrl", 64'(shctrl), 64'(!cur.mplier[it_exp]));
                    chk("alu_en", 64'(alu_en), 64'(cur.mplier[it_exp]));
                end
            end else if (done) begin
                chk("done_active", 64'(active), 64'd1);
                chk("done_cycle", 64'(edge_cnt), 64'(cur.load_edge + W + 1));
                chk("product", prod, cur.exp_prod);
                chk("done_busy", 64'(busy), 64'd1);
                active    = 1'b0;
                ready_exp = 1'b1;
            end else begin
                chk("idle_quiet", 64'({busy, alu_en}), 64'd0);
            end
        end
    end

    task automatic push_job(input logic [31:0] a, input logic [31:0] b, input int le);
        sb.push_back('{mcand: a, mplier: b, exp_prod: 64'(a) * 64'(b), load_edge: le});
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int repulse);
        int s;
        @(negedge clk);
        s = edge_cnt + 1;
        push_job(a, b, s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (repulse >= 0) begin
            repeat (repulse + 1) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (W + 4) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        reset  = 1'b0;
        start  = 1'b0;
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        run_job(32'd15, 32'd3, -1);
        run_job(32'h1234_5678, 32'd0, -1);
        run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_job($urandom, $urandom, 10);

        // Abort a multiply at iteration 5, then run a full one.
        @(negedge clk);
        s = edge_cnt + 1;
        push_job(32'd11, 32'd13, s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_iter", 64'(iter), 64'd5);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_state", 64'(dut32.state), 64'(IDLE));
        run_job(32'd7, 32'd9, -1);

        // Start held high: back-to-back multiplies 35 cycles apart.
        @(negedge clk);
        s = edge_cnt + 1;
        push_job(32'd5, 32'd6, s);
        push_job(32'hDEAD_BEEF, 32'h0000_FFFF, s + 35);
        push_job(32'd1, 32'h8000_0001, s + 70);
        start = 1'b1;
        repeat (71) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // WIDTH=4 instance, multiplier 4'b1010, multiplicand 3.
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("w4_load", 64'(wrctrl4), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w4_onehot", 64'($onehot0({wrctrl4, strctrl4, shctrl4})), 64'd1);
            chk("w4_iter", 64'(iter4), 64'(k));
            chk("w4_strctrl", 64'(strctrl4), 64'(pat_str[k]));
            chk("w4_shctrl", 64'(shctrl4), 64'(!pat_str[k]));
            chk("w4_alu_en", 64'(alu_en4), 64'(pat_str[k]));
            chk("w4_busy", 64'(busy4), 64'd1);
        end
        @(negedge clk);
        chk("w4_done", 64'(done4), 64'd1);
        chk("w4_product", 64'(prod4), 64'd30);
        @(negedge clk);
        chk("w4_done_pulse", 64'(done4), 64'd0);
        chk("w4_ready", 64'(ready4), 64'd1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("no_active_job", 64'(active), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Sequencing FSM for the shift-add multiplier datapath: the Multiplicand register, the 32-bit adder and the 64-bit Product register.
- Accepts a start request, loads the multiplier into Product[31:0], and runs WIDTH iterations.
- Each iteration is either add-and-shift or shift-only, chosen by the Product LSB.
- Signals completion to the requester with a done pulse and a held ready level.

Parameters:
- WIDTH, 32, operand width; also the number of iterations. Legal: power of two, 4..64.
- CNT_W, $clog2(WIDTH), iteration counter width. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request to begin a multiply. Sampled only in IDLE.
- product_lsb  input  1  Product_out[0] from the Product register.
- wrctrl  output  1  Product load: lower half <= multiplier, upper half <= 0.
- strctrl  output  1  Product add-and-shift write: {carry,sum,lower} >> 1.
- shctrl  output  1  Product shift-only: whole register >> 1.
- alu_en  output  1  adder operand enable. Equals strctrl.
- ready  output  1  Product contents are the final result; the Product register freezes.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle completion pulse.
- iter  output  CNT_W  current iteration index, for debug and bench checks.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state <= IDLE, iter <= 0.
  - All outputs 0, including ready.
  - Applies from any state. An aborted multiply leaves the Product contents undefined, and ready stays 0.
- FSM states: IDLE, LOAD, ITER, DONE. State is registered. All control outputs are Moore-decoded from state, except strctrl and shctrl, which also depend on product_lsb.
- IDLE:
  - busy=0. ready holds its previous value.
  - start==1 -> LOAD. Otherwise stay.
- LOAD:
  - wrctrl=1, busy=1, ready<=0, iter<=0.
  - Unconditionally -> ITER.
- ITER:
  - busy=1.
  - product_lsb==1: strctrl=1, alu_en=1, shctrl=0.
  - product_lsb==0: shctrl=1, strctrl=0.
  - Exactly one of strctrl/shctrl is high every ITER cycle.
  - iter increments each cycle.
  - When iter==WIDTH-1 -> DONE, and iter wraps to 0. Never count past WIDTH-1.
- DONE:
  - done=1 for this cycle only. ready<=1, busy=1.
  - Unconditionally -> IDLE.
  - ready stays 1 until the next LOAD.
- Latency, with start sampled high at edge 0:
  - wrctrl is high in cycle 1.
  - Iterations occupy cycles 2..WIDTH+1.
  - done is high in cycle WIDTH+2.
  - Total is WIDTH+3 cycles from start to done, inclusive.
- Handshake and boundaries:
  - start asserted in LOAD, ITER or DONE is ignored. It is not queued.
  - start held high continuously restarts a multiply: one cycle of IDLE after each DONE, then LOAD.
  - product_lsb is don't-care outside ITER.
  - wrctrl, strctrl and shctrl are mutually exclusive in every cycle. A bench assertion checks this.
  - An X on product_lsb in ITER is an error. The bench flags it; the RTL does not mask it.

Decomposition:
- Shared package mult_pkg holds:
  - the state typedef (IDLE=2'd0, LOAD=2'd1, ITER=2'd2, DONE=2'd3);
  - the WIDTH default constant.
- The datapath registers (Product, Multiplicand) and the product testbench reuse this package.
- One natural sub-module: mult_iter_cnt, a CNT_W-bit counter with clear, enable and terminal-count output, with a synchronous active-low reset.
- Everything else stays in mult_ctrl.

Test Plan:
- Reset during ITER at iter==5 -> next cycle state IDLE, iter=0, all outputs 0, ready=0. A following start runs a full WIDTH+3-cycle sequence.
- Multiply 3 x 15, WIDTH=32, with the bench modelling Product so product_lsb follows the real shifting register:
  - wrctrl high in cycle 1;
  - strctrl high in iterations 0-1, shctrl high in iterations 2-31;
  - done in cycle 34;
  - final bench Product = 64'd45;
  - ready=1 until the next start.
- Multiplier 0 -> strctrl never asserted, shctrl high for 32 cycles, Product = 0, done at cycle 34.
- Multiplier 32'hFFFFFFFF x 32'hFFFFFFFF -> strctrl high all 32 iterations, Product = 64'hFFFFFFFE00000001.
- start re-pulsed during ITER at iter==10 -> ignored: done still at cycle 34 and no second LOAD. Held-high start -> back-to-back multiplies with LOAD at cycles 1, 36, 71.
- WIDTH=4 build, multiplier 4'b1010 -> per-iteration pattern shctrl, strctrl, shctrl, strctrl, then done at cycle 6.
